// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the M-extension execution unit.
//   - OPCODE_OP / FUNCT7_MULDIV identify an M-ext instruction in the decoder.
//   - F3_* select the eight multiply/divide operations.
//   - mdu_state_t is the sequencer FSM encoding.
//   - ALU_OP_* are the ALU operation codes shared with the control unit.
package mdu_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;
    localparam logic [3:0] ALU_OP_MDU  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // True when the decoded instruction belongs to this unit.
    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative radix-2 restoring divider on unsigned operands.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   load                 capture dividend/divisor and begin XLEN iterations
//   kill                 abandon the current division
//   dividend, divisor    unsigned operands (divisor must be non-zero)
//   quotient, remainder  result of the iteration performed at the next edge
//   last                 the next edge performs the final iteration, so
//                        quotient/remainder are the finished result now
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            kill,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CNT_W = $clog2(XLEN);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;   // dividend bits shift out the top, quotient bits in the bottom
    logic [XLEN-1:0]  dvs_q;

    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;
    logic [XLEN-1:0]  rem_nx;
    logic [XLEN-1:0]  quo_nx;

    // rem_q < divisor always holds, so the shifted partial remainder fits in
    // XLEN+1 bits and the top bit of the difference is the borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (diff[XLEN]) begin
            rem_nx = rem_shift[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
        end else if (kill) begin
            active_q <= 1'b0;
        end else if (load) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= dividend;
            dvs_q    <= divisor;
        end else if (active_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                active_q <= 1'b0;
            end
        end
    end

    assign quotient  = quo_nx;
    assign remainder = rem_nx;
    assign last      = active_q && (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RISC-V M-extension unit for the EX stage.
// Multiplies take MUL_CYCLES cycles on a fixed-latency multiplier; divides
// run XLEN iterations of mdu_divider. Divide-by-zero and signed overflow
// finish without iterating.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start_i          instruction present; held by the pipeline until done_o
//   funct3_i         operation select
//   operand_a_i/b_i  rs1 / rs2
//   flush_i          kill the in-flight operation
//   busy_o           FSM not idle
//   done_o           one-cycle registered completion strobe
//   result_o         registered result, held until the next completion
//   stall_o          start_i & ~done_o, for the hazard logic
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);

    localparam logic [2:0]      MUL_LOAD = 3'(MUL_CYCLES - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t      state_q, state_d;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            a_sgn_q, b_sgn_q;   // operand is negative and treated as signed
    logic [2:0]      mul_cnt_q;

    logic            accept;
    logic            a_sgn_in, b_sgn_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    logic signed [2*XLEN+1:0] product;
    logic [XLEN-1:0] mul_res;
    logic [1:0]      unused_product;

    logic            div_load, div_kill, div_last;
    logic [XLEN-1:0] div_quo, div_rem, div_res;

    logic            res_load;
    logic [XLEN-1:0] res_d;

    // done_o is still high for the instruction just finished while the
    // pipeline holds start_i into the next edge; it must not restart.
    assign accept = (state_q == ST_IDLE) && start_i && !flush_i && !done_o;

    assign a_sgn_in = operand_a_i[XLEN-1] &&
                      (funct3_i == F3_MULH || funct3_i == F3_MULHSU ||
                       funct3_i == F3_DIV  || funct3_i == F3_REM);
    assign b_sgn_in = operand_b_i[XLEN-1] &&
                      (funct3_i == F3_MULH || funct3_i == F3_DIV || funct3_i == F3_REM);

    assign div_zero    = (operand_b_i == '0);
    assign div_ovf     = !funct3_i[0] && (operand_a_i == INT_MIN) && (operand_b_i == '1);
    assign special     = funct3_i[2] && (div_zero || div_ovf);
    assign special_res = div_zero ? (funct3_i[1] ? operand_a_i : '1)
                                  : (funct3_i[1] ? '0 : INT_MIN);

    // Sign flag as an extra top bit gives the (XLEN+1)-bit operand each
    // multiply variant needs.
    assign product        = $signed({a_sgn_q, a_q}) * $signed({b_sgn_q, b_q});
    assign mul_res        = (f3_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    assign unused_product = product[2*XLEN+1:2*XLEN];

    mdu_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .kill      (div_kill),
        .dividend  (a_sgn_in ? -operand_a_i : operand_a_i),
        .divisor   (b_sgn_in ? -operand_b_i : operand_b_i),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // Sign flags are only ever set for DIV/REM, so the unsigned ops pass through.
    assign div_res = f3_q[1] ? (a_sgn_q ? -div_rem : div_rem)
                             : ((a_sgn_q ^ b_sgn_q) ? -div_quo : div_quo);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!funct3_i[2]) state_d = ST_MUL;
                        else if (special) state_d = ST_DONE;
                        else              state_d = ST_DIV;
                    end
                end
                ST_MUL:  if (mul_cnt_q == '0) state_d = ST_DONE;
                ST_DIV:  if (div_last)        state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        stall_o  = start_i && !done_o;
        div_load = accept && funct3_i[2] && !special;
        div_kill = flush_i;
        res_load = 1'b0;
        res_d    = result_o;
        case (state_q)
            ST_IDLE: if (accept && special) begin
                res_load = 1'b1;
                res_d    = special_res;
            end
            ST_MUL: if (!flush_i && mul_cnt_q == '0) begin
                res_load = 1'b1;
                res_d    = mul_res;
            end
            ST_DIV: if (!flush_i && div_last) begin
                res_load = 1'b1;
                res_d    = div_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_o    <= 1'b0;
            result_o  <= '0;
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_sgn_q   <= 1'b0;
            b_sgn_q   <= 1'b0;
            mul_cnt_q <= '0;
        end else begin
            // Completion is committed once DONE is reached; a flush there is too late.
            done_o <= (state_q == ST_DONE);
            if (res_load) begin
                result_o <= res_d;
            end
            if (accept) begin
                f3_q    <= funct3_i;
                a_q     <= operand_a_i;
                b_q     <= operand_b_i;
                a_sgn_q <= a_sgn_in;
                b_sgn_q <= b_sgn_in;
            end
            if (accept && !funct3_i[2]) begin
                mul_cnt_q <= MUL_LOAD;
            end else if (state_q == ST_MUL && mul_cnt_q != '0) begin
                mul_cnt_q <= mul_cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 2;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opa, opb;
    logic        flush;
    logic        busy, done, stall;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result;

    mdu_sequencer #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .funct3_i    (funct3),
        .operand_a_i (opa),
        .operand_b_i (opb),
        .flush_i     (flush),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result),
        .stall_o     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the RISC-V M-extension definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFF_FFFF;
                  else if (a == MINV && b == 32'hFFFF_FFFF) r = MINV;
                  else r = ia / ib;
            3'd5: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == MINV && b == 32'hFFFF_FFFF) r = 32'd0;
                  else r = ia % ib;
            default: if (b == 0) r = a; else r = a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return MUL_CYCLES + 1;
        if (b == 0) return 1;
        if (!f3[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Issue one instruction and hold start until the pipeline would see done.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp_res;
        int exp_k, k;
        logic stall_ok, busy_ok;
        exp_res = ref_result(f3, a, b);
        exp_k   = ref_latency(f3, a, b);
        start  = 1'b1;
        funct3 = f3;
        opa    = a;
        opb    = b;
        #1;
        stall_ok = (stall === 1'b1);
        busy_ok  = 1'b1;
        k = 0;
        while (k < 60) begin
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) break;
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(k - 1), 32'(exp_k));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stall_wait"}, 32'(stall_ok), 32'd1);
        check({tag, "_busy_wait"}, 32'(busy_ok), 32'd1);
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_no_restart"}, 32'(busy), 32'd0);
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        last_result = exp_res;
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int sel;
        logic saw_done;

        rst_n = 1'b0; start = 1'b0; funct3 = '0; opa = '0; opb = '0; flush = 1'b0;
        last_result = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        // flush in IDLE blocks acceptance
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; opa = 32'd2; opb = 32'd2;
        @(posedge clk); #1;
        check("flush_idle_busy", 32'(busy), 32'd0);
        start = 1'b0; flush = 1'b0;

        run_op("mul_neg",    3'd0, 32'd7,        32'hFFFF_FFFD);
        run_op("mulh_min",   3'd1, MINV,         MINV);
        run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 3'd5, 32'd100,      32'd7);
        run_op("remu_100_7", 3'd7, 32'd100,      32'd7);
        run_op("divu_by0",   3'd5, 32'd5,        32'd0);
        run_op("rem_by0",    3'd6, 32'd5,        32'd0);
        run_op("div_ovf",    3'd4, MINV,         32'hFFFF_FFFF);
        run_op("rem_ovf",    3'd6, MINV,         32'hFFFF_FFFF);

        // flush 10 cycles into a divide
        start = 1'b1; funct3 = 3'd4; opa = 32'd1000; opb = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result_kept", result, last_result);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("flush_no_done", 32'(saw_done), 32'd0);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4);

        // reset in the middle of a divide
        start = 1'b1; funct3 = 3'd4; opa = 32'd100; opb = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        run_op("div_after_rst", 3'd4, 32'd9, 32'd3);

        // random operations, with corner operands mixed in
        for (int i = 0; i < 24; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = MINV; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = {1'b1, ra[30:0]};
            run_op($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
